// File: rtl/wash_pkg.sv
// Shared constants and small helpers for the washing-machine sequencer.
package wash_pkg;

  // Phase/state codes (also driven out on the phase port)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WASH  = 3'd1;
  localparam logic [2:0] ST_RINSE = 3'd2;
  localparam logic [2:0] ST_SPIN  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Program selector codes
  localparam logic [1:0] MODE_SPIN  = 2'b00;
  localparam logic [1:0] MODE_SMALL = 2'b01;
  localparam logic [1:0] MODE_MED   = 2'b10;
  localparam logic [1:0] MODE_LARGE = 2'b11;

  // Motor action digits
  localparam logic [3:0] ACT_IDLE = 4'd0;
  localparam logic [3:0] ACT_DASH = 4'd10;

  // Phase lamps
  localparam logic [7:0] LED_IDLE  = 8'h04;
  localparam logic [7:0] LED_WASH  = 8'h08;
  localparam logic [7:0] LED_RINSE = 8'h10;
  localparam logic [7:0] LED_SPIN  = 8'h20;
  localparam logic [7:0] LED_DONE  = 8'h40;
  localparam logic [7:0] LED_PAUSE = 8'h80;

  // Action digit for a phase at a given step of its pattern
  function automatic logic [3:0] act_code(input logic [2:0] st, input logic [1:0] step);
    logic [3:0] a;
    a = ACT_IDLE;
    case (st)
      ST_WASH:  a = step[0] ? 4'd2 : 4'd1;
      ST_RINSE: a = (step == 2'd0) ? 4'd3 : (step == 2'd1) ? 4'd1 : 4'd4;
      ST_SPIN: begin
        case (step)
          2'd0:    a = 4'd5;
          2'd2:    a = 4'd6;
          default: a = 4'd4;
        endcase
      end
      ST_DONE:  a = ACT_DASH;
      default:  a = ACT_IDLE;
    endcase
    return a;
  endfunction

  // Advance the step counter, wrapping at the phase's pattern length
  function automatic logic [1:0] step_next(input logic [2:0] st, input logic [1:0] step);
    logic [1:0] s;
    s = 2'd0;
    case (st)
      ST_WASH:  s = {1'b0, ~step[0]};
      ST_RINSE: s = (step == 2'd2) ? 2'd0 : step + 2'd1;
      ST_SPIN:  s = step + 2'd1;
      default:  s = 2'd0;
    endcase
    return s;
  endfunction

  // One-hot lamp for a phase (pause bit ORed in separately)
  function automatic logic [7:0] led_of(input logic [2:0] st);
    logic [7:0] l;
    l = LED_IDLE;
    case (st)
      ST_WASH:  l = LED_WASH;
      ST_RINSE: l = LED_RINSE;
      ST_SPIN:  l = LED_SPIN;
      ST_DONE:  l = LED_DONE;
      default:  l = LED_IDLE;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/wash_tick_gen.sv
// One-second tick prescaler; counts only while enabled, cleared on phase change.
module wash_tick_gen #(
  parameter int CLK_HZ = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

  logic [W-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  // Prescaler: hold when disabled so a paused second resumes where it stopped
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/wash_seq.sv
// Washing-machine program sequencer: IDLE -> WASH -> RINSE xN -> SPIN -> DONE.
module wash_seq
  import wash_pkg::*;
#(
  parameter int CLK_HZ  = 100000000,
  parameter int WASH_S  = 20,
  parameter int STEP_S  = 5,
  parameter int RINSE_S = 10,
  parameter int SPIN_S  = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       on,
  input  logic       start_p,
  input  logic       pause_p,
  input  logic [1:0] mode,
  output logic [2:0] phase,
  output logic [7:0] phase_led,
  output logic [3:0] action,
  output logic [3:0] rem_tens,
  output logic [3:0] rem_ones,
  output logic       busy,
  output logic       done
);
  localparam int MAX_TOTAL = WASH_S + 2*STEP_S + 2*RINSE_S + SPIN_S;

  // The BCD display only has two digits, so the longest program must fit
  if (MAX_TOTAL > 99) begin : g_total_chk
    $fatal(1, "wash_seq: large program total exceeds 99 s");
  end

  localparam logic [6:0] WASH_L  = 7'(WASH_S);
  localparam logic [6:0] STEP_L  = 7'(STEP_S);
  localparam logic [6:0] RINSE_L = 7'(RINSE_S);
  localparam logic [6:0] SPIN_L  = 7'(SPIN_S);

  logic [2:0] st, st_n;
  logic       paused, paused_n;
  logic [6:0] phase_rem;
  logic [1:0] reps_left;
  logic [1:0] step;
  logic       tick, go, fin, clr;

  logic [6:0] wash_len, rinse_tot, total;
  logic [1:0] reps;

  assign phase = st;
  assign busy  = (st == ST_WASH) || (st == ST_RINSE) || (st == ST_SPIN);
  assign done  = (st == ST_DONE);

  assign go  = on && (st == ST_IDLE) && start_p;
  assign fin = tick && (phase_rem == 7'd1);
  assign clr = on && (st == ST_DONE) && start_p;

  wash_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (busy && !paused && on),
    .clear  (go || fin || clr),
    .tick   (tick)
  );

  // Program table decoded from the mode selector
  always_comb begin
    wash_len  = 7'd0;
    rinse_tot = 7'd0;
    reps      = 2'd0;
    case (mode)
      MODE_SMALL: begin wash_len = WASH_L;                   reps = 2'd1; rinse_tot = RINSE_L;           end
      MODE_MED:   begin wash_len = WASH_L + STEP_L;          reps = 2'd2; rinse_tot = RINSE_L + RINSE_L; end
      MODE_LARGE: begin wash_len = WASH_L + STEP_L + STEP_L; reps = 2'd2; rinse_tot = RINSE_L + RINSE_L; end
      default:    begin wash_len = 7'd0;                     reps = 2'd0; rinse_tot = 7'd0;              end
    endcase
    total = wash_len + rinse_tot + SPIN_L;
  end

  // Next phase and pause flag
  always_comb begin
    st_n     = st;
    paused_n = paused;
    if (on) begin
      if (busy && pause_p) paused_n = !paused;
      case (st)
        ST_IDLE:  if (start_p) st_n = (wash_len == 7'd0) ? ST_SPIN : ST_WASH;
        ST_WASH:  if (fin) st_n = (reps_left != 2'd0) ? ST_RINSE : ST_SPIN;
        ST_RINSE: if (fin) st_n = (reps_left > 2'd1) ? ST_RINSE : ST_SPIN;
        ST_SPIN:  if (fin) begin st_n = ST_DONE; paused_n = 1'b0; end
        ST_DONE:  if (start_p) st_n = ST_IDLE;
        default:  st_n = ST_IDLE;
      endcase
    end
  end

  // Sequencer registers; everything holds while on is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= ST_IDLE;
      paused    <= 1'b0;
      phase_led <= LED_IDLE;
      phase_rem <= 7'd0;
      reps_left <= 2'd0;
      step      <= 2'd0;
      action    <= ACT_IDLE;
      rem_tens  <= 4'd0;
      rem_ones  <= 4'd0;
    end else if (on) begin
      st        <= st_n;
      paused    <= paused_n;
      phase_led <= led_of(st_n) | (paused_n ? LED_PAUSE : 8'h00);
      if (go) begin
        reps_left <= reps;
        phase_rem <= (wash_len == 7'd0) ? SPIN_L : wash_len;
        step      <= 2'd0;
        action    <= act_code(st_n, 2'd0);
        rem_tens  <= 4'(total / 7'd10);
        rem_ones  <= 4'(total % 7'd10);
      end else if (clr) begin
        action <= ACT_IDLE;
      end else if (tick) begin
        if (rem_ones != 4'd0) rem_ones <= rem_ones - 4'd1;
        else if (rem_tens != 4'd0) begin
          rem_tens <= rem_tens - 4'd1;
          rem_ones <= 4'd9;
        end
        if (fin) begin
          phase_rem <= (st_n == ST_RINSE) ? RINSE_L : (st_n == ST_SPIN) ? SPIN_L : 7'd0;
          step      <= 2'd0;
          action    <= act_code(st_n, 2'd0);
          if (st == ST_RINSE) reps_left <= reps_left - 2'd1;
          if (st_n == ST_DONE) begin
            rem_tens <= 4'd0;
            rem_ones <= 4'd0;
          end
        end else begin
          phase_rem <= phase_rem - 7'd1;
          step      <= step_next(st, step);
          action    <= act_code(st, step_next(st, step));
        end
      end
    end
  end
endmodule

// File: doc/wash_seq.md
Name: wash_seq

Overview:
- Parametrised washing-machine program sequencer; successor to the fixed-time single-mode controller.
- Runs IDLE → WASH → RINSE (N repeats) → SPIN → DONE with per-mode durations, pause/resume, a BCD remaining-time countdown, a per-second motor action code and phase lamps.
- Sits between the debounced button edge detectors and the 4-digit 7-seg scanner plus the LED bank.

Parameters:
- CLK_HZ, 100000000, clock cycles per 1 s tick.
- WASH_S, 20, base wash seconds (small load).
- STEP_S, 5, extra wash seconds per load size step.
- RINSE_S, 10, seconds per rinse repeat.
- SPIN_S, 20, spin seconds.
- Elaboration check: program total (largest is large mode) ≤ 99, else fatal.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- on  in  1  power/enable; 0 freezes all state, outputs hold.
- start_p  in  1  one-cycle start pulse, already debounced.
- pause_p  in  1  one-cycle pause-toggle pulse, already debounced.
- mode  in  2  00 spin-only, 01 small, 10 medium, 11 large; sampled on accepted start.
- phase  out  3  state code (package enum).
- phase_led  out  8  one-hot phase lamp; bit7 = paused.
- action  out  4  motor action digit for the scanner.
- rem_tens  out  4  remaining seconds, BCD tens.
- rem_ones  out  4  remaining seconds, BCD ones.
- busy  out  1  high in WASH/RINSE/SPIN.
- done  out  1  high in DONE.

Behaviour:
- Reset (async, any time including mid-cycle): state IDLE, paused 0, prescaler 0, action 0, rem 00, phase_led 0000_0100, busy 0, done 0.
- on=0: every register holds; pulses that arrive are dropped.
- Tick: prescaler counts 0..CLK_HZ-1 only while busy && !paused && on; tick is a 1-cycle pulse at CLK_HZ-1, then wraps to 0. Prescaler clears on every state change.
- Program table, latched from mode on accepted start:
  - 00: wash 0, rinse 0 repeats, spin SPIN_S.
  - 01: wash WASH_S, 1 repeat.
  - 10: wash WASH_S+STEP_S, 2 repeats.
  - 11: wash WASH_S+2*STEP_S, 2 repeats.
  - All non-zero-wash modes spin SPIN_S.
- IDLE: start_p → first non-zero phase (WASH, or SPIN for mode 00) on the next edge. Phase seconds load that phase's length; rem loads the program total in BCD. pause_p is ignored; if start_p and pause_p arrive together, start wins.
- Each tick: phase_rem−1 and BCD rem−1 (ones 0 → 9 with tens−1). BCD never goes below 00.
- Phase end: on the tick where phase_rem==1, move to the next phase and load its length.
  - RINSE re-enters RINSE until the repeat count is used up, then goes to SPIN.
  - SPIN goes to DONE; rem is 00 on the same edge.
- pause_p while busy toggles paused. When paused, prescaler, counters and action freeze. Resume continues from the frozen prescaler value, with no lost partial second. start_p while busy is ignored.
- DONE: action=10 (dash), done=1. start_p → IDLE, and a new program needs a second start_p.
- Action code: updates on entry and on each tick using the per-phase step counter (cleared on phase entry).
  - IDLE 0.
  - WASH alternates 1,2.
  - RINSE cycles 3,1,4.
  - SPIN cycles 5,4,6,4.
- phase_led: IDLE bit2, WASH bit3, RINSE bit4, SPIN bit5, DONE bit6, OR bit7 when paused. Registered, same edge as state.

Decomposition:
- wash_pkg: state enum (IDLE, WASH, RINSE, SPIN, DONE), mode codes, action codes, LED one-hot constants.
- Sub-module wash_tick_gen (CLK_HZ, enable, clear → tick) holds the prescaler.

Test Plan (CLK_HZ=4, WASH_S=3, STEP_S=2, RINSE_S=2, SPIN_S=2):
- mode=01, start_p → WASH, rem 07, action 1. After 3 ticks RINSE with rem 04; after 2 more SPIN with rem 02; after 2 more DONE, rem 00, action 10, done=1.
- mode=00 start → SPIN directly with rem 02, action sequence 5,4, then DONE. mode=11 start → rem 13, BCD goes 10→09 cleanly, two RINSE repeats observed.
- pause_p mid-WASH at prescaler=2 → phase_led bit7=1, rem/action frozen for 20 cycles. pause_p again → next tick exactly 2 cycles later.
- start_p while busy and pause_p in IDLE → no effect. start_p+pause_p same cycle in IDLE → starts, not paused.
- rst asserted mid-RINSE (async, between edges) → outputs at reset values immediately. Deassert, then start → clean fresh program.
- on=0 for 10 cycles mid-SPIN with a start_p pulse during it → all outputs held, pulse lost. on=1 → countdown resumes where it stopped.
